// File: rtl/stream_select_n_pkg.sv
// Shared definitions for the stream selector: mode encodings and the
// offset helper for addressing one channel inside a flattened data bus.
package stream_select_n_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int slice_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/stream_select_n_rr_pick.sv
// Rotating-priority encoder: first set request at or after i_ptr, modulo N.
// Purely combinational; no backpressure of its own, callers gate the result.
module rr_pick
    import stream_select_n_pkg::*;
#(
    parameter int N     = 32,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_gnt,
    output logic             o_any
);

    localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic [SEL_W:0] w_sum;

    // Doubling the vector turns the wrap-around scan into a plain shift.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = N'(w_req2 >> i_ptr);

    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (SEL_W + 1)'(k);
                o_any = 1'b1;
            end
        end
        if (w_sum >= N_W) begin
            o_gnt = SEL_W'(w_sum - N_W);
        end else begin
            o_gnt = w_sum[SEL_W-1:0];
        end
    end

endmodule

// File: rtl/stream_select_n.sv
// N-way WIDTH-bit stream selector, fixed-index or round-robin grant, 1-cycle registered output.
// Backpressure: in_ready only rises when the output register is empty or draining this cycle.
module stream_select_n
    import stream_select_n_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 32,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready
);

    localparam int              DW   = $clog2(N * WIDTH);
    localparam logic [SEL_W:0]  N_W  = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_src;
    logic [SEL_W-1:0] r_ptr;

    logic [SEL_W-1:0] w_rr_gnt;
    logic             w_rr_any;
    logic             w_fix_ok;
    logic [SEL_W-1:0] w_gnt;
    logic             w_gv;
    logic             w_load;
    logic             w_take;
    logic [DW-1:0]    w_base;
    logic [WIDTH-1:0] w_word;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .i_req (in_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_any (w_rr_any)
    );

    // An out-of-range index must never grant, even if it aliases a valid bit.
    assign w_fix_ok = ({1'b0, sel} < N_W) && in_valid[sel];

    always_comb begin
        w_gnt = '0;
        w_gv  = 1'b0;
        if (mode == MODE_RR) begin
            w_gnt = w_rr_gnt;
            w_gv  = w_rr_any;
        end else if (w_fix_ok) begin
            w_gnt = sel;
            w_gv  = 1'b1;
        end
    end

    // reset_n gates the grant so no producer sees ready while reset is held.
    assign w_load   = ~r_valid | out_ready;
    assign w_take   = w_load & w_gv & reset_n;
    assign in_ready = w_take ? (N'(1) << w_gnt) : '0;

    assign w_base = DW'(slice_off(int'(w_gnt), WIDTH));
    assign w_word = in_data[w_base +: WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_take) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
                r_src   <= w_gnt;
                if (mode == MODE_RR) begin
                    r_ptr <= (w_gnt == LAST) ? '0 : w_gnt + SEL_W'(1);
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_stream_select_n.sv
// Bench for stream_select_n: a 32-channel and a 5-channel instance driven from a vector table,
// with expected words queued at grant time and compared as the consumer drains them.
module tb_stream_select_n;

    localparam int W  = 32;
    localparam int NA = 32;
    localparam int NB = 5;
    localparam int SA = 5;
    localparam int SB = 3;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] V3  = 32'h4000_0208;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic            a_mode, a_ordy, a_ov;
    logic [SA-1:0]   a_sel, a_os;
    logic [NA-1:0]   a_vld, a_rdy;
    logic [NA*W-1:0] a_data;
    logic [W-1:0]    a_od;

    logic            b_mode, b_ordy, b_ov;
    logic [SB-1:0]   b_sel, b_os;
    logic [NB-1:0]   b_vld, b_rdy;
    logic [NB*W-1:0] b_data;
    logic [W-1:0]    b_od;

    stream_select_n #(.WIDTH(W), .N(NA)) dut_a (
        .clock(clock), .reset_n(reset_n), .mode(a_mode), .sel(a_sel),
        .in_valid(a_vld), .in_data(a_data), .in_ready(a_rdy),
        .out_valid(a_ov), .out_data(a_od), .out_src(a_os), .out_ready(a_ordy)
    );

    stream_select_n #(.WIDTH(W), .N(NB)) dut_b (
        .clock(clock), .reset_n(reset_n), .mode(b_mode), .sel(b_sel),
        .in_valid(b_vld), .in_data(b_data), .in_ready(b_rdy),
        .out_valid(b_ov), .out_data(b_od), .out_src(b_os), .out_ready(b_ordy)
    );

    typedef struct {
        logic        dut;
        logic        mode;
        logic [5:0]  sel;
        logic [31:0] vld;
        logic        ordy;
        logic        gv;
        logic [5:0]  gnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  src;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    logic eov[2];
    int   checks = 0;
    int   failures = 0;
    logic cur = 1'b0;

    logic        cur_ov;
    logic [31:0] cur_od;
    logic [31:0] cur_rdy;
    logic [5:0]  cur_os;

    always_comb begin
        cur_ov  = cur ? b_ov : a_ov;
        cur_od  = cur ? b_od : a_od;
        cur_rdy = cur ? {27'b0, b_rdy} : a_rdy;
        cur_os  = cur ? {3'b0, b_os} : {1'b0, a_os};
    end

    function automatic logic [31:0] word(input logic d, input int i);
        if (!d && i == 17) return 32'hDEAD_BEEF;
        return {(d ? 8'hB0 : 8'hA0), 8'(i), 16'h5A00 + 16'(i)};
    endfunction

    function automatic vec_t mk(input logic d, input logic m, input int s, input logic [31:0] v,
                                input logic r, input logic g, input int n);
        vec_t x;
        x.dut = d; x.mode = m; x.sel = 6'(s); x.vld = v;
        x.ordy = r; x.gv = g; x.gnt = 6'(n);
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int tag, input vec_t v);
        logic        load;
        logic [63:0] exp_rdy;
        exp_t        e;
        cur = v.dut;
        if (!v.dut) begin
            a_mode = v.mode; a_sel = v.sel[SA-1:0]; a_vld = v.vld[NA-1:0]; a_ordy = v.ordy;
        end else begin
            b_mode = v.mode; b_sel = v.sel[SB-1:0]; b_vld = v.vld[NB-1:0]; b_ordy = v.ordy;
        end
        #1;
        load    = !eov[cur] || v.ordy;
        exp_rdy = (load && v.gv) ? (64'd1 << v.gnt) : 64'd0;
        chk($sformatf("row%0d_in_ready", tag), 64'(cur_rdy), exp_rdy);
        chk($sformatf("row%0d_pre_valid", tag), 64'(cur_ov), 64'(eov[cur]));
        if (eov[cur] && v.ordy) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL row%0d_scoreboard actual=empty required=entry", tag);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("row%0d_drain_data", tag), 64'(cur_od), 64'(e.data));
                chk($sformatf("row%0d_drain_src", tag), 64'(cur_os), 64'(e.src));
            end
        end
        if (load && v.gv) begin
            e.data = word(cur, int'(v.gnt));
            e.src  = v.gnt;
            sbq.push_back(e);
            eov[cur] = 1'b1;
        end else if (v.ordy) begin
            eov[cur] = 1'b0;
        end
        @(posedge clock);
        #1;
        chk($sformatf("row%0d_out_valid", tag), 64'(cur_ov), 64'(eov[cur]));
        if (eov[cur] && sbq.size() != 0) begin
            chk($sformatf("row%0d_out_data", tag), 64'(cur_od), 64'(sbq[$].data));
            chk($sformatf("row%0d_out_src", tag), 64'(cur_os), 64'(sbq[$].src));
        end
    endtask

    initial begin
        eov[0] = 1'b0;
        eov[1] = 1'b0;
        for (int i = 0; i < NA; i++) a_data[i*W +: W] = word(1'b0, i);
        for (int i = 0; i < NB; i++) b_data[i*W +: W] = word(1'b1, i);

        reset_n = 1'b0;
        a_mode = 1'b1; a_sel = '0; a_vld = '1; a_ordy = 1'b1;
        b_mode = 1'b1; b_sel = '0; b_vld = '1; b_ordy = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_out_data", 64'(a_od), 64'd0);
        chk("rst_out_src", 64'(a_os), 64'd0);
        chk("rst_in_ready_a", 64'(a_rdy), 64'd0);
        chk("rst_in_ready_b", 64'(b_rdy), 64'd0);
        a_vld = '0;
        b_vld = '0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 32-channel instance
        tbl.push_back(mk(0, 1, 0,  ALL, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0,  ALL, 1, 1, 1));
        tbl.push_back(mk(0, 0, 17, ALL, 1, 1, 17));
        tbl.push_back(mk(0, 0, 17, ALL, 1, 1, 17));
        tbl.push_back(mk(0, 1, 0,  ALL, 1, 1, 2));
        tbl.push_back(mk(0, 1, 0,  V3,  1, 1, 3));
        tbl.push_back(mk(0, 1, 0,  V3,  1, 1, 9));
        tbl.push_back(mk(0, 1, 0,  V3,  1, 1, 30));
        tbl.push_back(mk(0, 1, 0,  V3,  1, 1, 3));
        tbl.push_back(mk(0, 1, 0,  V3,  1, 1, 9));
        tbl.push_back(mk(0, 1, 0,  V3,  1, 1, 30));
        tbl.push_back(mk(0, 0, 5,  V3,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0,   1, 0, 0));
        tbl.push_back(mk(0, 0, 7,  ALL, 1, 1, 7));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 8, ALL, 0, 1, 8));
        tbl.push_back(mk(0, 0, 9,  ALL, 1, 1, 9));
        tbl.push_back(mk(0, 1, 0,  0,   1, 0, 0));
        tbl.push_back(mk(0, 1, 0,  ALL, 1, 1, 31));
        tbl.push_back(mk(0, 1, 0,  ALL, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0,  0,   1, 0, 0));
        // 5-channel instance: wrap from 4 to 0, out-of-range select
        tbl.push_back(mk(1, 1, 0, 32'h08, 1, 1, 3));
        tbl.push_back(mk(1, 1, 0, 32'h11, 1, 1, 4));
        tbl.push_back(mk(1, 1, 0, 32'h11, 1, 1, 0));
        tbl.push_back(mk(1, 0, 6, 32'h1F, 1, 0, 0));
        tbl.push_back(mk(1, 0, 6, 32'h1F, 1, 0, 0));
        tbl.push_back(mk(1, 0, 7, 32'h1F, 1, 0, 0));
        tbl.push_back(mk(1, 0, 4, 32'h1F, 1, 1, 4));
        tbl.push_back(mk(1, 1, 0, 32'h1F, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h00, 1, 0, 0));

        for (int r = 0; r < tbl.size(); r++) step(r, tbl[r]);

        // Reset while a word is stalled in the output register
        step(100, mk(0, 0, 4, ALL, 1, 1, 4));
        step(101, mk(0, 0, 4, ALL, 0, 1, 4));
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(a_ov), 64'd0);
        chk("midrst_out_data", 64'(a_od), 64'd0);
        chk("midrst_in_ready", 64'(a_rdy), 64'd0);
        sbq.delete();
        eov[0] = 1'b0;
        eov[1] = 1'b0;
        a_vld = '0;
        b_vld = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(102, mk(0, 1, 0, ALL, 1, 1, 0));
        step(103, mk(0, 1, 0, 0,   1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
